aes_fifo_sram_sequencer: RTL and testbench

Sequencer on the FPGA side of the HPS→FPGA AES path. It drains 32-bit command/data words from the HPS-to-FPGA FIFO output port and assembles 128-bit key and plaintext blocks. It drives the AES core through a start/done handshake and writes each 128-bit result as four words into the on-chip SRAM s1 port. It sits between the Computer_System FIFO/SRAM conduits and the AES core, and is the only master of both ports.

---
 rtl/aes_seq_pkg.sv | 25 ++
 rtl/aes_seq_word_packer.sv | 31 +++
 rtl/aes_fifo_sram_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_aes_fifo_sram_sequencer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_seq_pkg.sv
// Shared types and helpers for the AES FIFO/SRAM sequencer.
// AES_SEQ_WORD_SWAP_EN enables byte reversal of payload and SRAM words.
package aes_seq_pkg;

    localparam int FRAME_WORDS = 4;
    localparam int CMD_KEY_BIT = 31;

    typedef enum logic [2:0] {
        IDLE,
        FETCH_CMD,
        FETCH_DATA,
        KEY_LOAD,
        AES_START,
        AES_WAIT,
        WRITE,
        DONE_CHK
    } seq_state_e;

    function automatic logic [31:0] bswap32(
        input logic [31:0] w
    );
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_seq_word_packer.sv
// Assembles four 32-bit words into a 128-bit block, first word at [127:96].
// Word order is fixed by shifting, so idx only tracks progress.
module aes_seq_word_packer (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         push_i,
    input  logic [31:0]  din_i,
    output logic [127:0] data_o,
    output logic [1:0]   idx_o
);

    logic [127:0] data_q;
    logic [1:0]   idx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            idx_q  <= '0;
        end else if (clr_i) begin
            idx_q  <= '0;
        end else if (push_i) begin
            data_q <= {data_q[95:0], din_i};
            idx_q  <= idx_q + 2'd1;
        end
    end

    assign data_o = data_q;
    assign idx_o  = idx_q;

endmodule

// File: rtl/aes_fifo_sram_sequencer.sv
// FIFO-to-AES-to-SRAM frame sequencer; sole master of FIFO and SRAM ports.
// Optional AES_SEQ_WORD_SWAP_EN byte-reverses payload and SRAM words.
module aes_fifo_sram_sequencer
    import aes_seq_pkg::*;
#(
    parameter int SRAM_AW = 8,
    parameter int CNT_W   = 16
) (
    input  logic               clk_clk,
    input  logic               reset_reset_n,
    input  logic               enable,
    output logic               fifo_read,
    input  logic [31:0]        fifo_readdata,
    input  logic               fifo_waitrequest,
    output logic [127:0]       aes_key,
    output logic               aes_key_load,
    output logic [127:0]       aes_din,
    output logic               aes_start,
    input  logic               aes_busy,
    input  logic               aes_done,
    input  logic [127:0]       aes_dout,
    output logic [SRAM_AW-1:0] sram_address,
    output logic               sram_chipselect,
    output logic               sram_write,
    output logic               sram_clken,
    output logic [31:0]        sram_writedata,
    output logic [3:0]         sram_byteenable,
    output logic [SRAM_AW-1:0] wr_ptr,
    output logic [CNT_W-1:0]   blk_cnt,
    output logic               key_valid,
    output logic               err,
    output logic               busy
);

    seq_state_e         state_q, state_d;
    logic               is_key_q, is_key_d;
    logic               kvld_q, kvld_d;
    logic               err_q, err_d;
    logic [127:0]       key_q, key_d;
    logic [127:0]       din_q, din_d;
    logic [127:0]       res_q, res_d;
    logic [SRAM_AW-1:0] wptr_q, wptr_d;
    logic [CNT_W-1:0]   blk_q, blk_d;
    logic [1:0]         widx_q, widx_d;
    logic               kload_q, kload_d;
    logic               start_q, start_d;
    logic               frd_q, wen_q, busy_q;

    logic               accept;
    logic [31:0]        payload;
    logic [31:0]        wr_word;
    logic [127:0]       stage;
    logic [1:0]         pidx;

    assign accept = frd_q && !fifo_waitrequest;

`ifdef AES_SEQ_WORD_SWAP_EN
    assign payload = bswap32(fifo_readdata);
    assign wr_word = bswap32(res_q[127:96]);
`else
    assign payload = fifo_readdata;
    assign wr_word = res_q[127:96];
`endif

    aes_seq_word_packer u_packer (
        .clk    (clk_clk),
        .rst_n  (reset_reset_n),
        .clr_i  (accept && state_q == FETCH_CMD),
        .push_i (accept && state_q == FETCH_DATA),
        .din_i  (payload),
        .data_o (stage),
        .idx_o  (pidx)
    );

    always_comb begin
        state_d  = state_q;
        is_key_d = is_key_q;
        kvld_d   = kvld_q;
        err_d    = err_q;
        key_d    = key_q;
        din_d    = din_q;
        res_d    = res_q;
        wptr_d   = wptr_q;
        blk_d    = blk_q;
        widx_d   = widx_q;
        kload_d  = 1'b0;
        start_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (enable) state_d = FETCH_CMD;
            end
            FETCH_CMD: begin
                if (accept) begin
                    is_key_d = fifo_readdata[CMD_KEY_BIT];
                    state_d  = FETCH_DATA;
                end
            end
            FETCH_DATA: begin
                if (accept && pidx == 2'(FRAME_WORDS - 1)) begin
                    if (is_key_q) begin
                        state_d = KEY_LOAD;
                    end else if (kvld_q) begin
                        state_d = AES_START;
                    end else begin
                        err_d   = 1'b1;
                        state_d = DONE_CHK;
                    end
                end
            end
            KEY_LOAD: begin
                key_d   = stage;
                kload_d = 1'b1;
                kvld_d  = 1'b1;
                state_d = DONE_CHK;
            end
            AES_START: begin
                if (!aes_busy) begin
                    din_d   = stage;
                    start_d = 1'b1;
                    state_d = AES_WAIT;
                end
            end
            AES_WAIT: begin
                if (aes_done) begin
                    res_d   = aes_dout;
                    widx_d  = 2'd0;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                wptr_d = wptr_q + SRAM_AW'(1);
                res_d  = {res_q[95:0], 32'h0};
                widx_d = widx_q + 2'd1;
                if (widx_q == 2'(FRAME_WORDS - 1)) begin
                    blk_d   = blk_q + CNT_W'(1);
                    state_d = DONE_CHK;
                end
            end
            DONE_CHK: begin
                state_d = enable ? FETCH_CMD : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q  <= IDLE;
            is_key_q <= 1'b0;
            kvld_q   <= 1'b0;
            err_q    <= 1'b0;
            key_q    <= '0;
            din_q    <= '0;
            res_q    <= '0;
            wptr_q   <= '0;
            blk_q    <= '0;
            widx_q   <= '0;
            kload_q  <= 1'b0;
            start_q  <= 1'b0;
            frd_q    <= 1'b0;
            wen_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            is_key_q <= is_key_d;
            kvld_q   <= kvld_d;
            err_q    <= err_d;
            key_q    <= key_d;
            din_q    <= din_d;
            res_q    <= res_d;
            wptr_q   <= wptr_d;
            blk_q    <= blk_d;
            widx_q   <= widx_d;
            kload_q  <= kload_d;
            start_q  <= start_d;
            // decode from next state so strobes line up with the state
            frd_q    <= state_d == FETCH_CMD || state_d == FETCH_DATA;
            wen_q    <= state_d == WRITE;
            busy_q   <= state_d != IDLE;
        end
    end

    assign fifo_read       = frd_q;
    assign aes_key         = key_q;
    assign aes_key_load    = kload_q;
    assign aes_din         = din_q;
    assign aes_start       = start_q;
    assign sram_address    = wptr_q;
    assign sram_chipselect = wen_q;
    assign sram_write      = wen_q;
    assign sram_clken      = wen_q;
    assign sram_writedata  = wr_word;
    assign sram_byteenable = 4'hF;
    assign wr_ptr          = wptr_q;
    assign blk_cnt         = blk_q;
    assign key_valid       = kvld_q;
    assign err             = err_q;
    assign busy            = busy_q;

endmodule

// File: tb/tb_aes_fifo_sram_sequencer.sv
// Directed bench: FIFO source, stub AES core and SRAM sink around the DUT.
// Stub AES returns the FIPS-197 ciphertext for its vector, else din ^ key.
module tb_aes_fifo_sram_sequencer;

    localparam int AW  = 8;
    localparam int CW  = 16;
    localparam int LAT = 10;

    localparam logic [127:0] FK = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FP = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic          fifo_read;
    logic [31:0]   fifo_readdata;
    logic          fifo_waitrequest;
    logic [127:0]  aes_key;
    logic          aes_key_load;
    logic [127:0]  aes_din;
    logic          aes_start;
    logic          aes_busy = 1'b0;
    logic          aes_done = 1'b0;
    logic [127:0]  aes_dout = '0;
    logic [AW-1:0] sram_address;
    logic          sram_chipselect, sram_write, sram_clken;
    logic [31:0]   sram_writedata;
    logic [3:0]    sram_byteenable;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] blk_cnt;
    logic          key_valid, err, busy;

    always #5 clk = ~clk;

    aes_fifo_sram_sequencer #(.SRAM_AW(AW), .CNT_W(CW)) dut (
        .clk_clk          (clk),
        .reset_reset_n    (rst_n),
        .enable           (enable),
        .fifo_read        (fifo_read),
        .fifo_readdata    (fifo_readdata),
        .fifo_waitrequest (fifo_waitrequest),
        .aes_key          (aes_key),
        .aes_key_load     (aes_key_load),
        .aes_din          (aes_din),
        .aes_start        (aes_start),
        .aes_busy         (aes_busy),
        .aes_done         (aes_done),
        .aes_dout         (aes_dout),
        .sram_address     (sram_address),
        .sram_chipselect  (sram_chipselect),
        .sram_write       (sram_write),
        .sram_clken       (sram_clken),
        .sram_writedata   (sram_writedata),
        .sram_byteenable  (sram_byteenable),
        .wr_ptr           (wr_ptr),
        .blk_cnt          (blk_cnt),
        .key_valid        (key_valid),
        .err              (err),
        .busy             (busy)
    );

    // FIFO source
    logic [31:0] fmem [0:1023];
    int          rd_i = 0;
    int          wr_i = 0;
    logic        stall = 1'b0;

    assign fifo_waitrequest = (rd_i == wr_i) || stall;
    assign fifo_readdata    = fmem[rd_i[9:0]];

    always @(posedge clk)
        if (fifo_read && !fifo_waitrequest) rd_i <= rd_i + 1;

    // stub AES core
    int           acnt = 0;
    logic [127:0] mk = '0, md = '0;

    function automatic logic [127:0] aes_model(
        input logic [127:0] k, input logic [127:0] d
    );
        if (k == FK && d == FP) return FC;
        return d ^ k;
    endfunction

    always @(posedge clk) begin
        aes_done <= 1'b0;
        if (aes_start) begin
            aes_busy <= 1'b1;
            acnt     <= LAT;
            mk       <= aes_key;
            md       <= aes_din;
        end else if (aes_busy) begin
            if (acnt == 1) begin
                aes_busy <= 1'b0;
                aes_done <= 1'b1;
                aes_dout <= aes_model(mk, md);
            end
            acnt <= acnt - 1;
        end
    end

    // SRAM sink and pulse counters
    logic [31:0] smem [0:(1<<AW)-1];
    int          nwr = 0;
    int          nkl = 0;

    always @(posedge clk) begin
        if (sram_chipselect && sram_write) begin
            smem[sram_address] <= sram_writedata;
            nwr <= nwr + 1;
        end
        if (aes_key_load) nkl <= nkl + 1;
    end

    int errs   = 0;
    int checks = 0;

    function automatic logic [31:0] tbsw(input logic [31:0] w);
`ifdef AES_SEQ_WORD_SWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    task automatic chk(
        input string tag,
        input logic [127:0] obs,
        input logic [127:0] exp
    );
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] w);
        fmem[wr_i[9:0]] = w;
        wr_i++;
    endtask

    task automatic push_frame(input bit is_key, input logic [127:0] p);
        push({is_key, 31'h0});
        for (int i = 0; i < 4; i++) push(tbsw(p[127-32*i -: 32]));
    endtask

    task automatic wait_blk(input int n, input int budget);
        int k = 0;
        while (int'(blk_cnt) != n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk($sformatf("blk_cnt_%0d", n), 128'(blk_cnt), 128'(n));
    endtask

    task automatic chk_blk(input string tag, input int a,
                           input logic [127:0] r);
        for (int i = 0; i < 4; i++)
            chk($sformatf("%s_w%0d", tag, i), 128'(smem[a+i]),
                128'(tbsw(r[127-32*i -: 32])));
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_ctl"}, 128'({fifo_read, aes_key_load, aes_start,
            sram_chipselect, sram_write, sram_clken, key_valid,
            err, busy}), 128'(0));
        chk({tag, "_be"}, 128'(sram_byteenable), 128'(4'hF));
        chk({tag, "_key"}, aes_key, 128'(0));
        chk({tag, "_din"}, aes_din, 128'(0));
        chk({tag, "_ptr"}, 128'({sram_address, wr_ptr, blk_cnt}), 128'(0));
        chk({tag, "_wdata"}, 128'(sram_writedata), 128'(0));
    endtask

    logic [127:0] p2, p3, pw;
    logic [31:0]  w0exp;
    int           k;

    initial begin
        rst_n  = 1'b0;
        enable = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_state("reset");
        rst_n = 1'b1;
        @(negedge clk);
        enable = 1'b1;

        // data before any key
        push_frame(1'b0, FP);
        k = 0;
        while (!err && k < 60) begin
            @(negedge clk);
            k++;
        end
        chk("nokey_err", 128'(err), 128'(1));
        repeat (20) @(negedge clk);
        chk("nokey_writes", 128'(nwr), 128'(0));
        chk("nokey_blk", 128'(blk_cnt), 128'(0));
        do_reset();

        // FIPS-197 key then plaintext
        push_frame(1'b1, FK);
        push_frame(1'b0, FP);
        wait_blk(1, 200);
        chk("fips_keyload_n", 128'(nkl), 128'(1));
        chk("fips_key", aes_key, FK);
        chk("fips_din", aes_din, FP);
        chk_blk("fips", 0, FC);
        chk("fips_wr_ptr", 128'(wr_ptr), 128'(4));

        // stalled FIFO between payload words 2 and 3, raw word 0
`ifdef AES_SEQ_WORD_SWAP_EN
        w0exp = 32'h00010203;
`else
        w0exp = 32'h03020100;
`endif
        p2 = {w0exp, 32'hdeadbeef, 32'h01234567, 32'h89abcdef};
        push(32'h0);
        push(32'h03020100);
        push(tbsw(p2[95:64]));
        push(tbsw(p2[63:32]));
        k = 0;
        while (rd_i != wr_i && k < 50) begin
            @(negedge clk);
            k++;
        end
        stall = 1'b1;
        push(tbsw(p2[31:0]));
        repeat (7) @(negedge clk);
        stall = 1'b0;
        wait_blk(2, 100);
        chk("stall_din", aes_din, p2);
        chk("swap_w0", 128'(aes_din[127:96]), 128'(w0exp));
        chk_blk("stall", 4, p2 ^ FK);
        chk("stall_wr_ptr", 128'(wr_ptr), 128'(8));
        chk("stall_fifo_drained", 128'(rd_i), 128'(wr_i));

        // ring wrap over 65 blocks
        do_reset();
        push_frame(1'b1, FK);
        for (int i = 1; i <= 65; i++) push_frame(1'b0, {4{i[31:0]}});
        wait_blk(65, 65 * 40);
        pw = {4{32'd65}};
        chk_blk("wrap65", 0, pw ^ FK);
        pw = {4{32'd64}};
        chk_blk("wrap64", 252, pw ^ FK);
        chk("wrap_wr_ptr", 128'(wr_ptr), 128'(4));

        // reset during the third write of a block
        p3 = 128'hfeedface_cafef00d_13579bdf_2468ace0;
        push_frame(1'b0, p3);
        k = 0;
        while (!(sram_write && sram_address == AW'(6)) && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("midwr_reached", 128'(sram_address), 128'(6));
        rst_n = 1'b0;
        #1;
        chk_reset_state("midwr");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        push_frame(1'b1, p3);
        k = 0;
        while (!key_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("post_rst_kvalid", 128'(key_valid), 128'(1));
        chk("post_rst_key", aes_key, p3);
        chk("post_rst_err", 128'({err, blk_cnt}), 128'(0));

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
